// File: rtl/fetch_pkg.sv
// Shared types, defaults and helpers for the N-wide fetch stage.
// Contents: parameter defaults, fetch queue entry type, lane address helper.
package fetch_pkg;

    localparam int unsigned ISSUE_W_DEF     = 2;
    localparam int unsigned QUEUE_DEPTH_DEF = 8;
    localparam int unsigned XLEN_DEF        = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

    // One fetch queue slot: the word and the address it was fetched from.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Address of lane 'lane' in a fetch group starting at 'base'.
    function automatic logic [XLEN_DEF-1:0] lane_pc(input logic [XLEN_DEF-1:0] base,
                                                    input int unsigned         lane);
        return base + XLEN_DEF'(lane * 4);
    endfunction

endpackage

// File: rtl/fetch_unit_nw_if.sv
// Bundle of the fetch stage's memory, redirect and decode-facing signals.
// master: fetch unit side (drives imem_addr_o and the queue head window).
// slave : environment side (instruction memory, execute redirect, decode).
interface fetch_unit_nw_if
    import fetch_pkg::*;
#(
    parameter int unsigned ISSUE_W     = ISSUE_W_DEF,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned XLEN        = XLEN_DEF
) ();

    localparam int unsigned DEQ_W = $clog2(ISSUE_W + 1);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [ISSUE_W*XLEN-1:0] imem_addr_o;
    logic [ISSUE_W*XLEN-1:0] imem_rdata_i;
    logic                    redirect_i;
    logic [XLEN-1:0]         redirect_pc_i;
    logic [DEQ_W-1:0]        deq_cnt_i;
    logic [ISSUE_W-1:0]      valid_o;
    logic [ISSUE_W*XLEN-1:0] instr_o;
    logic [ISSUE_W*XLEN-1:0] pc_o;
    logic [ISSUE_W*XLEN-1:0] pcplus4_o;
    logic [CNT_W-1:0]        count_o;

    modport master (
        output imem_addr_o, valid_o, instr_o, pc_o, pcplus4_o, count_o,
        input  imem_rdata_i, redirect_i, redirect_pc_i, deq_cnt_i
    );

    modport slave (
        input  imem_addr_o, valid_o, instr_o, pc_o, pcplus4_o, count_o,
        output imem_rdata_i, redirect_i, redirect_pc_i, deq_cnt_i
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue: ISSUE_W-wide all-or-nothing push, 0..ISSUE_W pop,
// flush, and a combinational read window of the ISSUE_W oldest entries.
// Ports: clk, rst (async, active-high), flush, push, push_data, pop_req,
//        rd_data/rd_valid (head window, lane 0 oldest), count (occupancy).
// The caller guarantees push only when at least ISSUE_W slots are free.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ISSUE_W     = ISSUE_W_DEF,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   push,
    input  fetch_entry_t [ISSUE_W-1:0]             push_data,
    input  logic [$clog2(ISSUE_W+1)-1:0]           pop_req,
    output fetch_entry_t [ISSUE_W-1:0]             rd_data,
    output logic [ISSUE_W-1:0]                     rd_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]       count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    fetch_entry_t     mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] pop_c;
    logic [CNT_W-1:0] push_n_c;

    // Clamp the pop request to what is actually stored.
    always_comb begin
        pop_c    = CNT_W'(pop_req);
        push_n_c = '0;
        if (pop_c > count) begin
            pop_c = count;
        end
        if (push) begin
            push_n_c = CNT_W'(ISSUE_W);
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_c);
            count <= count + push_n_c - pop_c;
            if (push) begin
                tail <= tail + PTR_W'(ISSUE_W);
            end
        end
    end

    // Storage; free space is checked pre-pop, so a push never lands on a live entry.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int unsigned i = 0; i < ISSUE_W; i++) begin
                mem[tail + PTR_W'(i)] <= push_data[i];
            end
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
        assign rd_data[g]  = mem[head + PTR_W'(g)];
        assign rd_valid[g] = CNT_W'(g) < count;
    end

endmodule

// File: rtl/fetch_unit_nw.sv
// N-wide fetch stage: owns the fetch PC, issues ISSUE_W sequential word
// addresses per cycle and queues the returned words for decode.
// Ports: clk, rst (async, active-high), bus (fetch_unit_nw_if.master):
//   imem_addr_o/imem_rdata_i  instruction memory lanes (lane 0 in LSBs)
//   redirect_i/redirect_pc_i  flush queue and reload the fetch PC
//   deq_cnt_i                 entries consumed by decode this cycle
//   valid_o/instr_o/pc_o/pcplus4_o/count_o  queue head window and occupancy
module fetch_unit_nw
    import fetch_pkg::*;
#(
    parameter int unsigned   ISSUE_W     = ISSUE_W_DEF,
    parameter int unsigned   QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned   XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_nw_if.master bus
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    if (XLEN != XLEN_DEF) begin : g_xlen_chk
        $error("fetch_unit_nw: XLEN must equal fetch_pkg::XLEN_DEF");
    end
    if ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || QUEUE_DEPTH < 2 * ISSUE_W) begin : g_depth_chk
        $error("fetch_unit_nw: QUEUE_DEPTH must be a power of two >= 2*ISSUE_W");
    end

    logic [XLEN-1:0]            fpc;
    logic                       push_c;
    logic [CNT_W-1:0]           count;
    fetch_entry_t [ISSUE_W-1:0] push_data;
    fetch_entry_t [ISSUE_W-1:0] rd_data;

    // Fetch only when a whole group fits, judged on pre-pop occupancy.
    always_comb begin
        push_c = !bus.redirect_i && ((CNT_W'(QUEUE_DEPTH) - count) >= CNT_W'(ISSUE_W));
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        assign bus.imem_addr_o[g*XLEN +: XLEN] = lane_pc(fpc, g);
        assign push_data[g].pc                 = lane_pc(fpc, g);
        assign push_data[g].instr              = bus.imem_rdata_i[g*XLEN +: XLEN];
        assign bus.instr_o[g*XLEN +: XLEN]     = rd_data[g].instr;
        assign bus.pc_o[g*XLEN +: XLEN]        = rd_data[g].pc;
        assign bus.pcplus4_o[g*XLEN +: XLEN]   = rd_data[g].pc + XLEN'(4);
    end

    // Fetch PC: redirect reloads (word aligned), a push advances one group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc <= RESET_PC;
        end else if (bus.redirect_i) begin
            fpc <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (push_c) begin
            fpc <= fpc + XLEN'(4 * ISSUE_W);
        end
    end

    fetch_queue #(
        .ISSUE_W     (ISSUE_W),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_i),
        .push      (push_c),
        .push_data (push_data),
        .pop_req   (bus.deq_cnt_i),
        .rd_data   (rd_data),
        .rd_valid  (bus.valid_o),
        .count     (count)
    );

    assign bus.count_o = count;

endmodule
